// File: rtl/unibus_arbiter_if.sv
// Unibus arbiter signal bundle: request/handshake inputs and grant outputs.
// arb_stats is present only when ARB_STATS_EN is defined.
interface unibus_arbiter_if;
    logic [7:4]  bus_br_in_l;
    logic        bus_npr_in_l;
    logic        bus_sack_in_l;
    logic        bus_bbsy_in_l;
    logic        bus_init_in_l;
    logic [2:0]  cpu_pri;
    logic        cpu_instend;
    logic        cpu_busreq;
    logic        cpu_busgnt;
    logic [7:4]  bus_bg_out_h;
    logic        bus_npg_out_h;
    logic [2:0]  arb_state;
`ifdef ARB_STATS_EN
    logic [31:0] arb_stats;
`endif

    modport master (
        input  bus_br_in_l, bus_npr_in_l, bus_sack_in_l, bus_bbsy_in_l, bus_init_in_l,
        input  cpu_pri, cpu_instend, cpu_busreq,
`ifdef ARB_STATS_EN
        output arb_stats,
`endif
        output cpu_busgnt, bus_bg_out_h, bus_npg_out_h, arb_state
    );

    modport slave (
        output bus_br_in_l, bus_npr_in_l, bus_sack_in_l, bus_bbsy_in_l, bus_init_in_l,
        output cpu_pri, cpu_instend, cpu_busreq,
`ifdef ARB_STATS_EN
        input  arb_stats,
`endif
        input  cpu_busgnt, bus_bg_out_h, bus_npg_out_h, arb_state
    );
endinterface

// File: rtl/unibus_arbiter.sv
// Central Unibus arbiter: NPR/BR grant issue, SACK handshake, CPU bus mastership.
// Define ARB_STATS_EN to add the saturating ack/timeout counters on arb_stats.
module unibus_arbiter #(
    parameter int SACK_TMO = 1000,
    parameter int DESKEW   = 8
) (
    input logic              CLOCK,
    input logic              RESET_N,
    unibus_arbiter_if.master bus
);
    localparam int TMO_W = $clog2(SACK_TMO + 1);
    localparam int DSK_W = $clog2(DESKEW + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CPU    = 3'd1,
        GRANT  = 3'd2,
        ACKED  = 3'd3,
        WAITBB = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [7:0]       sync_a, sync_b;
    logic [7:4]       br, br_pick;
    logic             npr, sack, bbsy, init;
    logic [7:4]       bg, bg_next;
    logic             npg, npg_next, cgnt, cgnt_next;
    logic [TMO_W-1:0] tmo, tmo_next;
    logic [DSK_W-1:0] dsk, dsk_next;
    logic             dsk_done;

    // Two-flop synchronizers; flops idle at the negated (high) level.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= {bus.bus_br_in_l, bus.bus_npr_in_l, bus.bus_sack_in_l,
                       bus.bus_bbsy_in_l, bus.bus_init_in_l};
            sync_b <= sync_a;
        end
    end

    assign {br, npr, sack, bbsy, init} = ~sync_b;
    assign dsk_done = (dsk == '0);

    always_comb begin
        br_pick = '0;
        for (int n = 4; n <= 7; n++) begin
            if (br[n] && bus.cpu_instend && (n > int'(bus.cpu_pri))) begin
                br_pick    = '0;
                br_pick[n] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        bg_next    = bg;
        npg_next   = npg;
        cgnt_next  = cgnt;
        tmo_next   = tmo;
        dsk_next   = dsk_done ? dsk : dsk - DSK_W'(1);
        case (state)
            IDLE: begin
                if (npr && dsk_done) begin
                    state_next = GRANT;
                    npg_next   = 1'b1;
                    tmo_next   = '0;
                end else if ((br_pick != '0) && dsk_done) begin
                    state_next = GRANT;
                    bg_next    = br_pick;
                    tmo_next   = '0;
                end else if (bus.cpu_busreq && !bbsy) begin
                    state_next = CPU;
                    cgnt_next  = 1'b1;
                end
            end
            CPU: begin
                // Releasing the CPU grant also restarts the deskew window.
                if (!bus.cpu_busreq) begin
                    state_next = IDLE;
                    cgnt_next  = 1'b0;
                    dsk_next   = DSK_W'(DESKEW);
                end
            end
            GRANT: begin
                if (sack) begin
                    state_next = ACKED;
                    bg_next    = '0;
                    npg_next   = 1'b0;
                    dsk_next   = DSK_W'(DESKEW);
                end else if (tmo == TMO_W'(SACK_TMO - 1)) begin
                    state_next = IDLE;
                    bg_next    = '0;
                    npg_next   = 1'b0;
                    dsk_next   = DSK_W'(DESKEW);
                end else begin
                    tmo_next = tmo + TMO_W'(1);
                end
            end
            ACKED: begin
                if (bbsy || !sack) state_next = WAITBB;
            end
            WAITBB: begin
                if (!bbsy && !sack) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                bg_next    = '0;
                npg_next   = 1'b0;
                cgnt_next  = 1'b0;
            end
        endcase
        if (init) begin
            state_next = IDLE;
            bg_next    = '0;
            npg_next   = 1'b0;
            cgnt_next  = 1'b0;
            tmo_next   = '0;
            dsk_next   = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            bg    <= '0;
            npg   <= 1'b0;
            cgnt  <= 1'b0;
            tmo   <= '0;
            dsk   <= '0;
        end else begin
            state <= state_next;
            bg    <= bg_next;
            npg   <= npg_next;
            cgnt  <= cgnt_next;
            tmo   <= tmo_next;
            dsk   <= dsk_next;
        end
    end

    assign bus.bus_bg_out_h  = bg;
    assign bus.bus_npg_out_h = npg;
    assign bus.cpu_busgnt    = cgnt;
    assign bus.arb_state     = state;

`ifdef ARB_STATS_EN
    logic [15:0] ack_cnt, to_cnt;
    logic        ack_evt, to_evt;

    assign ack_evt = (state == GRANT) && (state_next == ACKED);
    assign to_evt  = (state == GRANT) && (state_next == IDLE) && !init;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ack_cnt <= '0;
            to_cnt  <= '0;
        end else if (init) begin
            ack_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (ack_evt && (ack_cnt != 16'hFFFF)) ack_cnt <= ack_cnt + 16'd1;
            if (to_evt && (to_cnt != 16'hFFFF))   to_cnt  <= to_cnt + 16'd1;
        end
    end

    assign bus.arb_stats = {to_cnt, ack_cnt};
`endif
endmodule

// File: tb/tb_unibus_arbiter.sv
// Bench for unibus_arbiter: directed scenarios plus random traffic against an
// event-level model (cycle stamps for deskew/timeout). Honors ARB_STATS_EN.
module tb_unibus_arbiter;
    localparam int SACK_TMO = 1000;
    localparam int DESKEW   = 8;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLOCK = ~CLOCK;

    unibus_arbiter_if ifc ();

    unibus_arbiter #(.SACK_TMO(SACK_TMO), .DESKEW(DESKEW)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    // Model: who owns the bus, plus cycle stamps of the last grant and last drop.
    int         m_st;
    logic [7:4] m_bg;
    logic       m_npg, m_gnt;
    int         m_cyc = 0;
    int         m_drop, m_gcyc, m_acks, m_tmos;
    logic [7:0] m_s1 = '1;
    logic [7:0] m_s2 = '1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:4] pick_br(input logic [7:4] req, input logic [2:0] pri,
                                           input logic ie);
        logic [7:4] r;
        r = '0;
        if (ie) begin
            for (int n = 7; n >= 4; n--) begin
                if ((r == '0) && req[n] && (n > int'(pri))) r[n] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic m_clear();
        m_st = 0; m_bg = '0; m_npg = 1'b0; m_gnt = 1'b0;
        m_drop = m_cyc - 1000; m_gcyc = 0; m_acks = 0; m_tmos = 0;
    endtask

    task automatic m_release();
        m_bg = '0; m_npg = 1'b0; m_gnt = 1'b0; m_drop = m_cyc;
    endtask

    task automatic m_step(input logic [7:0] s);
        logic [7:4] rb, want;
        logic rn, rs, rbb, ri;
        {rb, rn, rs, rbb, ri} = s;
        m_cyc++;
        want = pick_br(rb, ifc.cpu_pri, ifc.cpu_instend);
        if (ri) m_clear();
        else begin
            case (m_st)
                0: if ((m_cyc - m_drop > DESKEW) && (rn || (want != '0))) begin
                       m_st = 2; m_gcyc = m_cyc;
                       if (rn) m_npg = 1'b1; else m_bg = want;
                   end else if (ifc.cpu_busreq && !rbb) begin
                       m_st = 1; m_gnt = 1'b1;
                   end
                1: if (!ifc.cpu_busreq) begin m_st = 0; m_release(); end
                2: if (rs) begin
                       m_st = 3; m_release();
                       if (m_acks < 65535) m_acks++;
                   end else if (m_cyc - m_gcyc == SACK_TMO) begin
                       m_st = 0; m_release();
                       if (m_tmos < 65535) m_tmos++;
                   end
                3: if (rbb || !rs) m_st = 4;
                4: if (!rbb && !rs) m_st = 0;
                default: m_st = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge CLOCK or negedge RESET_N);
        if (!RESET_N) begin
            m_clear(); m_s1 = '1; m_s2 = '1;
        end else begin
            m_step(~m_s2);
            m_s2 = m_s1;
            m_s1 = {ifc.bus_br_in_l, ifc.bus_npr_in_l, ifc.bus_sack_in_l,
                    ifc.bus_bbsy_in_l, ifc.bus_init_in_l};
        end
    end

    initial forever begin
        @(negedge CLOCK);
        if (cmp_on) begin
            chk("bg", 32'(ifc.bus_bg_out_h), 32'(m_bg));
            chk("npg", 32'(ifc.bus_npg_out_h), 32'(m_npg));
            chk("busgnt", 32'(ifc.cpu_busgnt), 32'(m_gnt));
            chk("state", 32'(ifc.arb_state), 32'(m_st));
            chk("onehot", 32'($onehot0({ifc.bus_npg_out_h, ifc.bus_bg_out_h, ifc.cpu_busgnt})), 32'd1);
`ifdef ARB_STATS_EN
            chk("stats", ifc.arb_stats, {m_tmos[15:0], m_acks[15:0]});
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic bus_idle();
        ifc.bus_br_in_l   = '1;
        ifc.bus_npr_in_l  = 1'b1;
        ifc.bus_sack_in_l = 1'b1;
        ifc.bus_bbsy_in_l = 1'b1;
        ifc.bus_init_in_l = 1'b1;
        ifc.cpu_busreq    = 1'b0;
    endtask

    initial begin
        int k;
        bus_idle();
        ifc.cpu_pri = 3'd0;
        ifc.cpu_instend = 1'b0;
        cyc(2);
        chk("rst_state", 32'(ifc.arb_state), 32'd0);
        chk("rst_grants", 32'({ifc.bus_npg_out_h, ifc.bus_bg_out_h, ifc.cpu_busgnt}), 32'd0);
        RESET_N = 1'b1;
        cmp_on  = 1'b1;
        cyc(2);

        // BR5 above priority 3: grant three clocks after the request.
        ifc.cpu_pri = 3'd3; ifc.cpu_instend = 1'b1; ifc.bus_br_in_l = 4'b1101;
        k = 0;
        do begin @(negedge CLOCK); k++; end while ((ifc.bus_bg_out_h == '0) && (k < 10));
        chk("br5_latency", 32'(k), 32'd3);
        chk("br5_grant", 32'(ifc.bus_bg_out_h), 32'h2);
        ifc.bus_sack_in_l = 1'b0; ifc.bus_br_in_l = '1;
        cyc(3);
        chk("br5_acked", 32'(ifc.arb_state), 32'd3);
        chk("br5_drop", 32'(ifc.bus_bg_out_h), 32'd0);
        ifc.bus_bbsy_in_l = 1'b0;
        cyc(3);
        chk("br5_waitbb", 32'(ifc.arb_state), 32'd4);
        ifc.bus_sack_in_l = 1'b1;
        cyc(3);
        chk("br5_bbsy_hold", 32'(ifc.arb_state), 32'd4);
        ifc.bus_bbsy_in_l = 1'b1;
        cyc(3);
        chk("br5_idle", 32'(ifc.arb_state), 32'd0);
        cyc(12);

        // BR5 masked by priority 5, then released by dropping to 4.
        ifc.cpu_pri = 3'd5; ifc.bus_br_in_l = 4'b1101;
        k = 0;
        repeat (2000) begin @(negedge CLOCK); if (ifc.bus_bg_out_h != '0) k++; end
        chk("pri_block", 32'(k), 32'd0);
        ifc.cpu_pri = 3'd4;
        @(negedge CLOCK);
        chk("pri_drop", 32'(ifc.bus_bg_out_h), 32'h2);
        ifc.bus_sack_in_l = 1'b0; ifc.bus_br_in_l = '1;
        cyc(3);
        chk("nobb_acked", 32'(ifc.arb_state), 32'd3);
        ifc.bus_sack_in_l = 1'b1;
        cyc(3);
        chk("nobb_waitbb", 32'(ifc.arb_state), 32'd4);
        cyc(1);
        chk("nobb_idle", 32'(ifc.arb_state), 32'd0);
        cyc(12);

        // NPR beats BR7; BR7 follows after the deskew window.
        ifc.cpu_pri = 3'd0; ifc.bus_npr_in_l = 1'b0; ifc.bus_br_in_l = 4'b0111;
        k = 0;
        do begin @(negedge CLOCK); k++; end while (!ifc.bus_npg_out_h && (k < 10));
        chk("npr_wins_npg", 32'(ifc.bus_npg_out_h), 32'd1);
        chk("npr_wins_bg", 32'(ifc.bus_bg_out_h), 32'd0);
        ifc.bus_npr_in_l = 1'b1; ifc.bus_sack_in_l = 1'b0;
        k = 0;
        do begin @(negedge CLOCK); k++; end while (ifc.bus_npg_out_h && (k < 10));
        chk("npr_acked", 32'(ifc.arb_state), 32'd3);
        ifc.bus_sack_in_l = 1'b1;
        k = 0;
        do begin @(negedge CLOCK); k++; end while ((ifc.bus_bg_out_h == '0) && (k < 30));
        chk("deskew_gap", 32'(k), 32'(DESKEW + 1));
        chk("br7_grant", 32'(ifc.bus_bg_out_h), 32'h8);
        ifc.bus_br_in_l = '1; ifc.bus_sack_in_l = 1'b0;
        cyc(3);
        ifc.bus_sack_in_l = 1'b1;
        cyc(16);

        // NPR with no SACK: grant withdrawn after SACK_TMO clocks.
        ifc.bus_npr_in_l = 1'b0;
        k = 0;
        do begin @(negedge CLOCK); k++; end while (!ifc.bus_npg_out_h && (k < 10));
        k = 0;
        do begin @(negedge CLOCK); k++; end while (ifc.bus_npg_out_h && (k < 1100));
        ifc.bus_npr_in_l = 1'b1;
        chk("tmo_len", 32'(k), 32'(SACK_TMO));
        chk("tmo_idle", 32'(ifc.arb_state), 32'd0);
`ifdef ARB_STATS_EN
        chk("tmo_stats", ifc.arb_stats, 32'h0001_0004);
`endif
        cyc(12);

        // CPU owns the bus; a pending NPR waits for it, then for deskew.
        ifc.cpu_busreq = 1'b1;
        @(negedge CLOCK);
        chk("cpu_gnt", 32'(ifc.cpu_busgnt), 32'd1);
        chk("cpu_state", 32'(ifc.arb_state), 32'd1);
        ifc.bus_npr_in_l = 1'b0;
        k = 0;
        repeat (20) begin @(negedge CLOCK); if (ifc.bus_npg_out_h) k++; end
        chk("cpu_no_preempt", 32'(k), 32'd0);
        chk("cpu_gnt_held", 32'(ifc.cpu_busgnt), 32'd1);
        ifc.cpu_busreq = 1'b0;
        k = 0;
        do begin @(negedge CLOCK); k++; end while (!ifc.bus_npg_out_h && (k < 30));
        chk("cpu_to_npg", 32'(k), 32'(DESKEW + 2));
        ifc.bus_npr_in_l = 1'b1; ifc.bus_sack_in_l = 1'b0;
        cyc(3);
        ifc.bus_bbsy_in_l = 1'b0;
        cyc(3);
        ifc.bus_sack_in_l = 1'b1;
        cyc(3);
        chk("init_pre", 32'(ifc.arb_state), 32'd4);
        ifc.bus_init_in_l = 1'b0;
        @(negedge CLOCK);
        ifc.bus_init_in_l = 1'b1;
        cyc(3);
        chk("init_state", 32'(ifc.arb_state), 32'd0);
        chk("init_grants", 32'({ifc.bus_npg_out_h, ifc.bus_bg_out_h, ifc.cpu_busgnt}), 32'd0);
`ifdef ARB_STATS_EN
        chk("init_stats", ifc.arb_stats, 32'd0);
`endif
        ifc.bus_bbsy_in_l = 1'b1;
        cyc(12);

        // Asynchronous reset while BG4 is out.
        ifc.cpu_pri = 3'd0; ifc.cpu_instend = 1'b1; ifc.bus_br_in_l = 4'b1110;
        k = 0;
        do begin @(negedge CLOCK); k++; end while ((ifc.bus_bg_out_h == '0) && (k < 10));
        chk("bg4_grant", 32'(ifc.bus_bg_out_h), 32'h1);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_bg", 32'(ifc.bus_bg_out_h), 32'd0);
        chk("async_rst_state", 32'(ifc.arb_state), 32'd0);
        ifc.bus_br_in_l = '1;
        cyc(2);
        RESET_N = 1'b1;
        cyc(3);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLOCK);
            if ($urandom_range(3) == 0) ifc.bus_br_in_l = 4'($urandom);
            if ($urandom_range(5) == 0) ifc.bus_npr_in_l = ($urandom_range(2) != 0);
            if ($urandom_range(2) == 0) ifc.bus_sack_in_l = 1'($urandom);
            if ($urandom_range(3) == 0) ifc.bus_bbsy_in_l = 1'($urandom);
            ifc.bus_init_in_l = ($urandom_range(300) != 0);
            if ($urandom_range(7) == 0) ifc.cpu_pri = 3'($urandom);
            if ($urandom_range(3) == 0) ifc.cpu_instend = 1'($urandom);
            if ($urandom_range(4) == 0) ifc.cpu_busreq = 1'($urandom);
        end
        bus_idle();
        cyc(20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
